// File: rtl/pipe_pkg.sv
// Shared constants and the scoreboard entry type for the pipeline hazard unit.
package pipe_pkg;

    localparam int unsigned REG_W    = 5;
    localparam int unsigned ZERO_REG = 31;
    localparam int unsigned FWD_RF   = 0;

    typedef struct packed {
        logic             valid;
        logic             wr;
        logic             ld;
        logic [REG_W-1:0] rd;
    } track_entry_t;

endpackage

// File: rtl/hazard_match.sv
// Matches one ID source register against the in-flight scoreboard; youngest producer wins.
module hazard_match
    import pipe_pkg::*;
#(
    parameter int unsigned NSTAGES    = 3,
    parameter int unsigned LOAD_STAGE = 2,
    parameter int unsigned ZERO_IDX   = ZERO_REG,
    parameter int unsigned FWD_W      = $clog2(NSTAGES + 1)
) (
    input  logic [REG_W-1:0] src,
    input  logic             used,
    input  track_entry_t     entries [NSTAGES],
    output logic [FWD_W-1:0] fwd,
    output logic             load_use
);

    logic             hit;
    logic             hit_ld;
    logic [FWD_W-1:0] hit_stage;

    // Scan oldest to youngest so the last assignment is the youngest producer.
    always_comb begin
        hit       = 1'b0;
        hit_ld    = 1'b0;
        hit_stage = '0;
        for (int k = int'(NSTAGES) - 1; k >= 0; k--) begin
            if (entries[k].valid && entries[k].wr && (entries[k].rd == src)) begin
                hit       = 1'b1;
                hit_ld    = entries[k].ld;
                hit_stage = FWD_W'(k + 1);
            end
        end
        if (!used || (src == REG_W'(ZERO_IDX))) begin
            hit = 1'b0;
        end
        load_use = hit && hit_ld && (hit_stage < FWD_W'(LOAD_STAGE));
        fwd      = (hit && !load_use) ? hit_stage : FWD_W'(FWD_RF);
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding controller beside ID: scoreboard of in-flight writers, forward selects, load-use stalls.
// Optional HAZARD_PERF_EN adds saturating stall/flush performance counters.
module pipe_hazard_unit
    import pipe_pkg::*;
#(
    parameter int unsigned NSTAGES    = 3,
    parameter int unsigned LOAD_STAGE = 2,
    parameter int unsigned FWD_W      = $clog2(NSTAGES + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               id_valid,
    input  logic [REG_W-1:0]   id_rs1,
    input  logic               id_rs1_used,
    input  logic [REG_W-1:0]   id_rs2,
    input  logic               id_rs2_used,
    input  logic [REG_W-1:0]   id_rd,
    input  logic               id_regwrite,
    input  logic               id_is_load,
    input  logic               flush,
    input  logic               mem_stall,
    output logic               issue,
    output logic               id_stall,
    output logic [FWD_W-1:0]   fwd_a,
    output logic [FWD_W-1:0]   fwd_b,
`ifdef HAZARD_PERF_EN
    output logic [31:0]        perf_stall_cycles,
    output logic [31:0]        perf_flushes,
`endif
    output logic [NSTAGES-1:0] stage_valid
);

    track_entry_t     sb [NSTAGES];
    track_entry_t     new_entry;
    logic [FWD_W-1:0] fwd_a_raw;
    logic [FWD_W-1:0] fwd_b_raw;
    logic             haz_a;
    logic             haz_b;
    logic             hazard;

    hazard_match #(
        .NSTAGES(NSTAGES), .LOAD_STAGE(LOAD_STAGE), .ZERO_IDX(ZERO_REG), .FWD_W(FWD_W)
    ) u_match_a (
        .src(id_rs1), .used(id_rs1_used), .entries(sb), .fwd(fwd_a_raw), .load_use(haz_a)
    );

    hazard_match #(
        .NSTAGES(NSTAGES), .LOAD_STAGE(LOAD_STAGE), .ZERO_IDX(ZERO_REG), .FWD_W(FWD_W)
    ) u_match_b (
        .src(id_rs2), .used(id_rs2_used), .entries(sb), .fwd(fwd_b_raw), .load_use(haz_b)
    );

    // All control outputs are forced inactive while reset is held low.
    assign hazard   = haz_a | haz_b;
    assign issue    = reset & id_valid & ~flush & ~hazard & ~mem_stall;
    assign id_stall = reset & (mem_stall | (hazard & id_valid & ~flush));
    assign fwd_a    = reset ? fwd_a_raw : '0;
    assign fwd_b    = reset ? fwd_b_raw : '0;

    always_comb begin
        new_entry = '0;
        if (issue) begin
            new_entry.valid = 1'b1;
            new_entry.wr    = id_regwrite;
            new_entry.ld    = id_is_load;
            new_entry.rd    = id_rd;
        end
    end

    // Scoreboard shift register; a frozen pipeline holds every entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < int'(NSTAGES); k++) begin
                sb[k] <= '0;
            end
        end else if (!mem_stall) begin
            sb[0] <= new_entry;
            for (int k = 1; k < int'(NSTAGES); k++) begin
                sb[k] <= sb[k-1];
            end
        end
    end

    always_comb begin
        stage_valid = '0;
        for (int k = 0; k < int'(NSTAGES); k++) begin
            stage_valid[k] = sb[k].valid;
        end
    end

`ifdef HAZARD_PERF_EN
    logic stall_evt;
    logic flush_evt;

    assign stall_evt = hazard & ~issue & ~mem_stall;
    assign flush_evt = flush & id_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stall_cycles <= '0;
            perf_flushes      <= '0;
        end else begin
            if (stall_evt && (perf_stall_cycles != 32'hFFFF_FFFF)) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
            if (flush_evt && (perf_flushes != 32'hFFFF_FFFF)) begin
                perf_flushes <= perf_flushes + 32'd1;
            end
        end
    end
`endif

endmodule
